matmul_host_link: RTL
=====================

MATMUL_HOST_LINK -- requirements
Module: matmul_host_link

Interface
REQ-001 Parameter: TIMEOUT, 1024, idle-cycle limit while awaiting result bytes (range 2..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load_we  input  1  operand buffer write strobe.
REQ-005 load_addr  input  5  operand byte index 0..17 (0..8 = A row-major, 9..17 = B row-major).
REQ-006 load_data  input  8  operand byte.
REQ-007 start  input  1  single-cycle transaction request.
REQ-008 tx_data  output  8  byte to multiplier ui_in.
REQ-009 tx_valid  output  1  byte-valid to multiplier uio_in[0].
REQ-010 rx_data  input  8  byte from multiplier uo_out.
REQ-011 rx_valid  input  1  byte-valid from multiplier uio_out[0].
REQ-012 rd_addr  input  4  result index 0..8 (C row-major).
REQ-013 rd_data  output  18  result word, combinational from rd_addr.
REQ-014 busy  output  1  high in SEND, WAIT, RECV.
REQ-015 done  output  1  high in DONE.
REQ-016 timeout_err  output  1  high in ERR.
REQ-017 fmt_err  output  1  sticky: a received high byte had bits [7:2] nonzero.

Function
REQ-018 States IDLE, SEND, WAIT, RECV, DONE, ERR; all outputs except rd_data registered.
REQ-019 load_we with load_addr <= 17 writes buffer only in IDLE, DONE, ERR; addr > 17 or other states: ignored.
REQ-020 start sampled in IDLE, DONE, ERR at edge t -> SEND; clears results to 0, done, timeout_err, fmt_err; start ignored in busy states.
REQ-021 start and load_we in same cycle: start wins, write discarded.
REQ-022 SEND: tx_valid = 1 during cycles t+1..t+18, tx_data = buffer[k] in cycle t+1+k, no gaps; then WAIT with tx_valid = 0, tx_data = 0.
REQ-023 rx_valid outside WAIT/RECV ignored.
REQ-024 WAIT/RECV: each rx_valid cycle captures one byte; byte n (0..26) -> result n/3, byte lane n%3, lane 0 = bits [7:0], lane 1 = [15:8], lane 2 = bits [17:16] from rx_data[1:0].
REQ-025 Lane-2 byte with rx_data[7:2] != 0: fmt_err set, bits discarded, capture continues.
REQ-026 First captured byte moves WAIT -> RECV.
REQ-027 Idle counter clears on entering WAIT and on each rx_valid, increments otherwise; reaching TIMEOUT -> ERR, captured results retained.
REQ-028 After byte 26 captured at edge e, state DONE from e; done level-high until next start or reset.
REQ-029 rd_addr > 8 -> rd_data = 0.
REQ-030 Latency: start to done = 18 + 1 + response cycles, with no extra pipeline stage after the last byte.

Reset
REQ-031 rst_n low: state IDLE; tx_valid, tx_data, busy, done, timeout_err, fmt_err = 0; results and operand buffer = 0; effective immediately, including mid-SEND or mid-RECV.
REQ-032 After rst_n release, first accepted start restarts at operand byte 0 and result byte 0.

Verification
REQ-033 A = identity, B = 1..9, model returns C -> 18 consecutive tx bytes 01 00 00 00 01 00 00 00 01 01..09; rd_data[i] = i+1 for i = 0..8; done = 1.
REQ-034 All operands 0xFF, response bytes 03 FA 02 x9 -> every rd_data = 0x2FA03; fmt_err = 0.
REQ-035 Response byte 2 = 0xFE (result 0 only) -> fmt_err = 1; rd_data[0] bits [17:16] = 2'b10; done = 1.
REQ-036 TIMEOUT = 16, model sends 5 bytes then stops -> timeout_err = 1 exactly 16 cycles after the last rx_valid; rd_data[0] holds bytes 0..2; rd_data[1] holds lane 0 and lane 1 only; busy = 0.
REQ-037 rst_n pulsed low at SEND byte 7 -> tx_valid = 0 immediately; subsequent reload + start sends the full 18 bytes from byte 0.
REQ-038 start during RECV and load_we during SEND -> ignored; buffer and capture unchanged.

Source files
------------

// File: rtl/matmul_host_link.sv
// Host-side link to a 3x3 byte matrix multiplier: streams 18 operand bytes out,
// collects 27 result bytes back into nine 18-bit words, with timeout and format checks.
module matmul_host_link #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_we,
    input  logic [4:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        start,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [3:0]  rd_addr,
    output logic [17:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        fmt_err
);

    localparam int unsigned NOPS = 18;
    localparam int unsigned NRES = 9;
    localparam int unsigned RW   = 18;
    localparam int unsigned CW   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      snd_q, snd_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic [3:0]      ridx_q, ridx_d;
    logic [1:0]      lane_q, lane_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            terr_q, terr_d;
    logic            ferr_q, ferr_d;
    logic            op_we, res_clr, res_we;

    logic [7:0]      opbuf_q [NOPS];
    logic [RW-1:0]   res_q   [NRES];

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        snd_d      = snd_q;
        idle_d     = idle_q;
        ridx_d     = ridx_q;
        lane_d     = lane_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = done_q;
        terr_d     = terr_q;
        ferr_d     = ferr_q;
        op_we      = 1'b0;
        res_clr    = 1'b0;
        res_we     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A start in the same cycle as a load discards the load
                if (start) begin
                    state_d    = S_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = opbuf_q[0];
                    snd_d      = 5'd1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    terr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    ridx_d     = '0;
                    lane_d     = '0;
                    res_clr    = 1'b1;
                end else if (load_we && (load_addr <= 5'(NOPS - 1))) begin
                    op_we = 1'b1;
                end
            end
            S_SEND: begin
                if (snd_q == 5'(NOPS)) begin
                    state_d    = S_WAIT;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                    idle_d     = '0;
                end else begin
                    tx_data_d = opbuf_q[snd_q];
                    snd_d     = snd_q + 5'd1;
                end
            end
            S_WAIT, S_RECV: begin
                if (rx_valid) begin
                    res_we  = 1'b1;
                    idle_d  = '0;
                    state_d = S_RECV;
                    if (lane_q == 2'd2) begin
                        lane_d = '0;
                        ridx_d = ridx_q + 4'd1;
                        if (rx_data[7:2] != 6'd0) begin
                            ferr_d = 1'b1;
                        end
                        if (ridx_q == 4'(NRES - 1)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    idle_d = idle_q + CW'(1);
                    if (idle_d == CW'(TIMEOUT)) begin
                        state_d = S_ERR;
                        terr_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, output and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            snd_q      <= '0;
            idle_q     <= '0;
            ridx_q     <= '0;
            lane_q     <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            for (int i = 0; i < int'(NOPS); i++) opbuf_q[i] <= '0;
            for (int i = 0; i < int'(NRES); i++) res_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            snd_q      <= snd_d;
            idle_q     <= idle_d;
            ridx_q     <= ridx_d;
            lane_q     <= lane_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            ferr_q     <= ferr_d;
            if (op_we) begin
                opbuf_q[load_addr] <= load_data;
            end
            if (res_clr) begin
                for (int i = 0; i < int'(NRES); i++) res_q[i] <= '0;
            end else if (res_we) begin
                // Only the two low bits of a lane-2 byte are meaningful
                case (lane_q)
                    2'd0:    res_q[ridx_q][7:0]   <= rx_data;
                    2'd1:    res_q[ridx_q][15:8]  <= rx_data;
                    default: res_q[ridx_q][17:16] <= rx_data[1:0];
                endcase
            end
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign fmt_err     = ferr_q;
    assign rd_data     = (rd_addr <= 4'(NRES - 1)) ? res_q[rd_addr] : '0;

endmodule
